// File: rtl/pivot_search.sv
// Partial-pivot search for one LU elimination column: scans rows col_k..last_row for the
// largest |element|, issues at most one row-swap request and reports pivot row / singular.
module pivot_search #(
  parameter int ROW_IDX_W = 8,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_IDX_W-1:0] col_k,
  input  logic [ROW_IDX_W-1:0] last_row,
  input  logic                 elem_valid,
  input  logic [DATA_W-1:0]    elem_data,
  output logic                 elem_ready,
  output logic                 pivot_req_valid,
  output logic [ROW_IDX_W-1:0] pivot_row_i,
  output logic [ROW_IDX_W-1:0] pivot_row_j,
  input  logic                 pivot_req_ready,
  input  logic                 pivot_done,
  output logic                 busy,
  output logic                 done,
  output logic [ROW_IDX_W-1:0] pivot_row,
  output logic                 singular
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, FIN} state_t;

  state_t state, state_nxt;

  logic [ROW_IDX_W-1:0] col_q, last_q, row_cnt, best, best_nxt;
  logic [DATA_W-1:0]    max_mag, max_nxt, mag;
  logic signed [DATA_W-1:0] elem_s;
  logic beat, is_last, upd, bad_range;

  // Magnitude is kept in DATA_W unsigned bits, so the most negative value maps exactly.
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] d);
    logic [DATA_W-1:0] u;
    u = d;
    return u[DATA_W-1] ? (~u + 1'b1) : u;
  endfunction

  assign elem_s    = elem_data;
  assign beat      = (state == SCAN) && elem_valid;
  assign mag       = abs_mag(elem_s);
  assign upd       = mag > max_mag;
  assign max_nxt   = upd ? mag : max_mag;
  assign best_nxt  = upd ? row_cnt : best;
  assign is_last   = (row_cnt == last_q);
  assign bad_range = (col_k > last_row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = bad_range ? FIN : SCAN;
      SCAN: begin
        if (beat && is_last) begin
          if (max_nxt == '0)          state_nxt = FIN;
          else if (best_nxt == col_q) state_nxt = FIN;
          else                        state_nxt = ISSUE;
        end
      end
      ISSUE: if (pivot_req_ready) state_nxt = WAIT;
      WAIT:  if (pivot_done) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Search datapath: capture on start, fold each accepted beat into the running maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      last_q    <= '0;
      row_cnt   <= '0;
      best      <= '0;
      max_mag   <= '0;
      pivot_row <= '0;
      singular  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        col_q    <= col_k;
        last_q   <= last_row;
        row_cnt  <= col_k;
        best     <= col_k;
        max_mag  <= '0;
        singular <= bad_range;
        if (bad_range) pivot_row <= col_k;
      end else if (beat) begin
        max_mag <= max_nxt;
        best    <= best_nxt;
        if (is_last) begin
          pivot_row <= best_nxt;
          singular  <= (max_nxt == '0);
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

  assign elem_ready      = (state == SCAN);
  assign pivot_req_valid = (state == ISSUE);
  assign pivot_row_i     = col_q;
  assign pivot_row_j     = best;
  assign busy            = (state != IDLE);
  assign done            = (state == FIN);

endmodule

// File: tb/tb_pivot_search.sv
// Scoreboard bench for pivot_search: directed columns push expected results; a monitor
// checks completions, swap handshakes and request stability; a small model answers swaps.
module tb_pivot_search;
  localparam int RW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, elem_valid, elem_ready;
  logic [RW-1:0] col_k, last_row, pivot_row_i, pivot_row_j, pivot_row;
  logic [DW-1:0] elem_data;
  logic          pivot_req_valid, pivot_req_ready, pivot_done, busy, done, singular;

  pivot_search #(.ROW_IDX_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .col_k(col_k), .last_row(last_row),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .pivot_req_valid(pivot_req_valid), .pivot_row_i(pivot_row_i), .pivot_row_j(pivot_row_j),
    .pivot_req_ready(pivot_req_ready), .pivot_done(pivot_done), .busy(busy), .done(done),
    .pivot_row(pivot_row), .singular(singular)
  );

  always #5 clk = ~clk;

  typedef struct {int row; int sing; int lat;} exp_t;

  exp_t exp_q[$];
  int   req_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, t0 = 0;
  logic hs_pending = 1'b0;
  logic signed [DW-1:0] dat [256];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Translation-unit model: pulses pivot_done one cycle after each handshake
  initial begin
    pivot_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pivot_done = 1'b0;
      if (hs_pending) begin
        pivot_done = 1'b1;
        hs_pending = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t    e;
    int      r;
    logic    prev_stall;
    logic [RW-1:0] prev_i, prev_j;
    prev_stall = 1'b0;
    prev_i = '0;
    prev_j = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected no completion");
          end else begin
            e = exp_q.pop_front();
            chk("pivot_row", pivot_row, e.row);
            chk("singular", singular, e.sing);
            if (e.lat > 0) chk("done_cycle", cyc - t0 + 1, e.lat);
          end
        end
        if (pivot_req_valid && prev_stall) begin
          chk("req_i_stable", pivot_row_i, prev_i);
          chk("req_j_stable", pivot_row_j, prev_j);
        end
        if (pivot_req_valid && pivot_req_ready) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_swap: got i=%0d j=%0d expected no request", pivot_row_i, pivot_row_j);
          end else begin
            r = req_q.pop_front();
            chk("req_i", pivot_row_i, r / 256);
            chk("req_j", pivot_row_j, r % 256);
          end
          hs_pending = 1'b1;
        end
        prev_stall = pivot_req_valid && !pivot_req_ready;
        prev_i     = pivot_row_i;
        prev_j     = pivot_row_j;
      end
    end
  end

  task automatic start_feed(input int k, input int last, input bit gaps);
    int  idx, guard;
    bit  acc;
    col_k    = RW'(k);
    last_row = RW'(last);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
    if (k <= last) begin
      idx   = 0;
      guard = 0;
      while (idx <= last - k && guard < 5000) begin
        elem_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        elem_data  = dat[idx];
        @(negedge clk);
        acc = elem_valid && elem_ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
        guard++;
      end
      elem_valid = 1'b0;
      if (guard >= 5000) begin
        checks++; errors++;
        $display("FAIL feed_timeout: got %0d beats expected %0d", idx, last - k + 1);
      end
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 600 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = pivot_req_valid;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no pivot_req_valid expected request");
    end
  endtask

  task automatic push_exp(input int row, input int sing, input int lat);
    exp_t e;
    e.row  = row;
    e.sing = sing;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_elem_ready"}, elem_ready, 0);
    chk({tag, "_req_valid"}, pivot_req_valid, 0);
    chk({tag, "_row_i"}, pivot_row_i, 0);
    chk({tag, "_row_j"}, pivot_row_j, 0);
    chk({tag, "_pivot_row"}, pivot_row, 0);
    chk({tag, "_singular"}, singular, 0);
  endtask

  initial begin
    exp_t tmp;
    int   tmpr;
    rst = 1'b1; start = 1'b0; col_k = '0; last_row = '0;
    elem_valid = 1'b0; elem_data = '0; pivot_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // swap: max 9 at row 3, tie at row 5 keeps row 3
    dat[0] = 3; dat[1] = -9; dat[2] = 4; dat[3] = 9;
    push_exp(3, 0, 7); req_q.push_back(2 * 256 + 3);
    start_feed(2, 5, 1'b0); wait_done();

    // no swap: |-100| at col_k wins
    dat[0] = -100; dat[1] = 5; dat[2] = 7; dat[3] = 99;
    push_exp(0, 0, 5);
    start_feed(0, 3, 1'b0); wait_done();

    // all-zero column
    dat[0] = 0; dat[1] = 0; dat[2] = 0;
    push_exp(4, 1, 4);
    start_feed(4, 6, 1'b0); wait_done();

    // bad range
    push_exp(7, 1, 1);
    start_feed(7, 6, 1'b0); wait_done();

    // most negative value outranks most positive
    dat[0] = 16'sh8000; dat[1] = 16'sh7FFF;
    push_exp(10, 0, 3);
    start_feed(10, 11, 1'b0); wait_done();

    // backpressure on both sides
    dat[0] = 3; dat[1] = -9; dat[2] = 4; dat[3] = 9;
    pivot_req_ready = 1'b0;
    push_exp(3, 0, -1); req_q.push_back(2 * 256 + 3);
    start_feed(2, 5, 1'b1);
    wait_valid();
    repeat (5) begin @(posedge clk); #1; end
    pivot_req_ready = 1'b1;
    wait_done();

    // full range, max at the last row
    for (int r = 0; r < 255; r++) dat[r] = DW'(r);
    dat[255] = 1000;
    push_exp(255, 0, 259); req_q.push_back(255);
    start_feed(0, 255, 1'b0); wait_done();

    // reset while in ISSUE
    dat[0] = 1; dat[1] = 2; dat[2] = 3; dat[3] = 4;
    pivot_req_ready = 1'b0;
    push_exp(3, 0, -1); req_q.push_back(3);
    start_feed(0, 3, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tmp  = exp_q.pop_back();
    tmpr = req_q.pop_back();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pivot_req_ready = 1'b1;
    dat[0] = -100; dat[1] = 5; dat[2] = 7; dat[3] = 99;
    push_exp(0, 0, 5);
    start_feed(0, 3, 1'b0); wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
